// File: rtl/dll_tx_arbiter.sv
// DLL transmit arbiter: DLLP, replay and new-TLP sources onto one PIPE path.
// Packet-atomic locking, link-state gating, bounded TLP starvation.
module dll_tx_arbiter #(
  parameter int DATA_W       = 256,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              sclk,
  input  logic              srst_n,
  input  logic [1:0]        dlcm_state_i,
  input  logic              dllp_valid_i,
  input  logic [DATA_W-1:0] dllp_data_i,
  output logic              dllp_ready_o,
  input  logic              rpl_valid_i,
  input  logic [DATA_W-1:0] rpl_data_i,
  input  logic              rpl_last_i,
  output logic              rpl_ready_o,
  input  logic              tlp_valid_i,
  input  logic [DATA_W-1:0] tlp_data_i,
  input  logic              tlp_last_i,
  output logic              tlp_ready_o,
  input  logic              pipe_ready_i,
  output logic              pipe_valid_o,
  output logic [DATA_W-1:0] pipe_data_o,
  output logic [1:0]        pipe_src_o,
  output logic [7:0]        starve_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCK_RPL = 2'd1,
    LOCK_TLP = 2'd2
  } state_t;

  localparam logic [1:0] SRC_DLLP = 2'd0;
  localparam logic [1:0] SRC_RPL  = 2'd1;
  localparam logic [1:0] SRC_TLP  = 2'd2;

  localparam logic [1:0] DL_INACTIVE = 2'd0;
  localparam logic [1:0] DL_ACTIVE   = 2'd3;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t state_q;
  state_t state_d;

  logic              load_en;
  logic              link_up;
  logic              dllp_ok;
  logic              rpl_ok;
  logic              tlp_ok;
  logic              promote;
  logic              gnt_dllp;
  logic              gnt_rpl;
  logic              gnt_tlp;
  logic              hs_dllp;
  logic              hs_rpl;
  logic              hs_tlp;
  logic              hs_any;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_src;
  logic [7:0]        starve_d;

  assign load_en = ~pipe_valid_o | pipe_ready_i;
  assign link_up = (dlcm_state_i == DL_ACTIVE);

  assign dllp_ok = dllp_valid_i & (dlcm_state_i != DL_INACTIVE);
  assign rpl_ok  = rpl_valid_i & link_up;
  assign tlp_ok  = tlp_valid_i & link_up;
  assign promote = tlp_ok & (starve_cnt_o >= LIMIT);

  // Grant selection: priority in IDLE, locked source only otherwise.
  always_comb begin
    gnt_dllp = 1'b0;
    gnt_rpl  = 1'b0;
    gnt_tlp  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (promote)      gnt_tlp  = 1'b1;
        else if (rpl_ok)  gnt_rpl  = 1'b1;
        else if (dllp_ok) gnt_dllp = 1'b1;
        else if (tlp_ok)  gnt_tlp  = 1'b1;
      end
      LOCK_RPL: gnt_rpl = rpl_ok;
      LOCK_TLP: gnt_tlp = tlp_ok;
      default: ;
    endcase
  end

  // A grant only completes when the output register can take the beat;
  // reset masks readies so nothing handshakes while the block is held.
  assign hs_dllp = gnt_dllp & load_en & srst_n;
  assign hs_rpl  = gnt_rpl  & load_en & srst_n;
  assign hs_tlp  = gnt_tlp  & load_en & srst_n;
  assign hs_any  = hs_dllp | hs_rpl | hs_tlp;

  assign dllp_ready_o = hs_dllp;
  assign rpl_ready_o  = hs_rpl;
  assign tlp_ready_o  = hs_tlp;

  // Steer the accepted beat and its source tag into the output stage.
  always_comb begin
    sel_data = '0;
    sel_src  = SRC_DLLP;
    unique case (1'b1)
      hs_tlp: begin
        sel_data = tlp_data_i;
        sel_src  = SRC_TLP;
      end
      hs_rpl: begin
        sel_data = rpl_data_i;
        sel_src  = SRC_RPL;
      end
      hs_dllp: begin
        sel_data = dllp_data_i;
        sel_src  = SRC_DLLP;
      end
      default: ;
    endcase
  end

  // Next-state: lock on a non-final beat, release on last beat or link drop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (hs_rpl & ~rpl_last_i)      state_d = LOCK_RPL;
        else if (hs_tlp & ~tlp_last_i) state_d = LOCK_TLP;
      end
      LOCK_RPL: begin
        if (!link_up)                 state_d = IDLE;
        else if (hs_rpl & rpl_last_i) state_d = IDLE;
      end
      LOCK_TLP: begin
        if (!link_up)                 state_d = IDLE;
        else if (hs_tlp & tlp_last_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Starvation count: grows while an eligible TLP loses IDLE arbitration.
  always_comb begin
    starve_d = starve_cnt_o;
    if (hs_tlp || !tlp_valid_i) begin
      starve_d = 8'd0;
    end else if ((state_q == IDLE) && load_en && tlp_ok &&
                 (gnt_rpl | gnt_dllp) && (starve_cnt_o != 8'hFF)) begin
      starve_d = starve_cnt_o + 8'd1;
    end
  end

  // FSM and starvation state registers.
  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      state_q      <= IDLE;
      starve_cnt_o <= 8'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_o <= starve_d;
    end
  end

  // Single output register; holds under backpressure, drains on ready.
  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      pipe_valid_o <= 1'b0;
      pipe_data_o  <= '0;
      pipe_src_o   <= SRC_DLLP;
    end else if (hs_any) begin
      pipe_valid_o <= 1'b1;
      pipe_data_o  <= sel_data;
      pipe_src_o   <= sel_src;
    end else if (pipe_ready_i) begin
      pipe_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dll_tx_arbiter.sv
// Directed bench for dll_tx_arbiter.
// Linear steps with hand-computed expectations.
module tb_dll_tx_arbiter;

  localparam int W = 256;

  logic         sclk = 1'b0;
  logic         srst_n;
  logic [1:0]   dlcm_state_i;
  logic         dllp_valid_i;
  logic [W-1:0] dllp_data_i;
  logic         dllp_ready_o;
  logic         rpl_valid_i;
  logic [W-1:0] rpl_data_i;
  logic         rpl_last_i;
  logic         rpl_ready_o;
  logic         tlp_valid_i;
  logic [W-1:0] tlp_data_i;
  logic         tlp_last_i;
  logic         tlp_ready_o;
  logic         pipe_ready_i;
  logic         pipe_valid_o;
  logic [W-1:0] pipe_data_o;
  logic [1:0]   pipe_src_o;
  logic [7:0]   starve_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 sclk = ~sclk;

  dll_tx_arbiter #(
    .DATA_W(W),
    .STARVE_LIMIT(8)
  ) dut (
    .sclk(sclk),
    .srst_n(srst_n),
    .dlcm_state_i(dlcm_state_i),
    .dllp_valid_i(dllp_valid_i),
    .dllp_data_i(dllp_data_i),
    .dllp_ready_o(dllp_ready_o),
    .rpl_valid_i(rpl_valid_i),
    .rpl_data_i(rpl_data_i),
    .rpl_last_i(rpl_last_i),
    .rpl_ready_o(rpl_ready_o),
    .tlp_valid_i(tlp_valid_i),
    .tlp_data_i(tlp_data_i),
    .tlp_last_i(tlp_last_i),
    .tlp_ready_o(tlp_ready_o),
    .pipe_ready_i(pipe_ready_i),
    .pipe_valid_o(pipe_valid_o),
    .pipe_data_o(pipe_data_o),
    .pipe_src_o(pipe_src_o),
    .starve_cnt_o(starve_cnt_o)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk_rdy(input string tag, input logic d,
                         input logic r, input logic t);
    chk({tag, "_dllp_rdy"}, W'(dllp_ready_o), W'(d));
    chk({tag, "_rpl_rdy"}, W'(rpl_ready_o), W'(r));
    chk({tag, "_tlp_rdy"}, W'(tlp_ready_o), W'(t));
  endtask

  initial begin
    srst_n       = 1'b0;
    dlcm_state_i = 2'd3;
    dllp_valid_i = 1'b1;
    dllp_data_i  = W'(256'hD0D0);
    rpl_valid_i  = 1'b1;
    rpl_data_i   = W'(256'hA0A0);
    rpl_last_i   = 1'b1;
    tlp_valid_i  = 1'b1;
    tlp_data_i   = W'(256'hB0B0);
    tlp_last_i   = 1'b1;
    pipe_ready_i = 1'b1;

    // 1: reset with everything requesting
    tick();
    tick();
    chk_rdy("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_valid", W'(pipe_valid_o), W'(0));
    chk("rst_data", pipe_data_o, W'(0));
    chk("rst_src", W'(pipe_src_o), W'(0));
    chk("rst_starve", W'(starve_cnt_o), W'(0));
    srst_n = 1'b1;
    #1;
    chk_rdy("post_rst", 1'b0, 1'b1, 1'b0);
    tick();
    chk("post_rst_src", W'(pipe_src_o), W'(1));
    chk("post_rst_valid", W'(pipe_valid_o), W'(1));
    chk("post_rst_data", pipe_data_o, W'(256'hA0A0));
    dllp_valid_i = 1'b0;
    rpl_valid_i  = 1'b0;
    tlp_valid_i  = 1'b0;
    tick();
    chk("drain_valid", W'(pipe_valid_o), W'(0));

    // 2: link in Init1, only DLLPs pass
    dlcm_state_i = 2'd1;
    dllp_valid_i = 1'b1;
    rpl_valid_i  = 1'b1;
    tlp_valid_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dllp_data_i = W'(256'hD100 + i);
      #1;
      chk_rdy("init1", 1'b1, 1'b0, 1'b0);
      tick();
      chk("init1_src", W'(pipe_src_o), W'(0));
      chk("init1_data", pipe_data_o, W'(256'hD100 + i));
    end
    chk("init1_starve", W'(starve_cnt_o), W'(0));
    dllp_valid_i = 1'b0;
    rpl_valid_i  = 1'b0;
    tlp_valid_i  = 1'b0;
    tick();

    // 3: 4-beat TLP holds off a DLLP arriving mid-packet
    dlcm_state_i = 2'd3;
    dllp_data_i  = W'(256'hD300);
    for (int i = 1; i <= 4; i++) begin
      tlp_valid_i  = 1'b1;
      tlp_data_i   = W'(256'h1000 + i);
      tlp_last_i   = (i == 4);
      dllp_valid_i = (i >= 2);
      #1;
      chk_rdy("lock_tlp", 1'b0, 1'b0, 1'b1);
      tick();
      chk("lock_tlp_src", W'(pipe_src_o), W'(2));
      chk("lock_tlp_data", pipe_data_o, W'(256'h1000 + i));
    end
    tlp_valid_i = 1'b0;
    tlp_last_i  = 1'b0;
    #1;
    chk_rdy("after_tlp", 1'b1, 1'b0, 1'b0);
    tick();
    chk("after_tlp_src", W'(pipe_src_o), W'(0));
    chk("after_tlp_data", pipe_data_o, W'(256'hD300));
    dllp_valid_i = 1'b0;
    tick();

    // 4: starvation promotion after 8 lost cycles
    chk("starve_start", W'(starve_cnt_o), W'(0));
    dllp_valid_i = 1'b1;
    tlp_valid_i  = 1'b1;
    tlp_last_i   = 1'b1;
    tlp_data_i   = W'(256'h2000);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk_rdy("starve_lose", 1'b1, 1'b0, 1'b0);
      tick();
      chk("starve_cnt", W'(starve_cnt_o), W'(i + 1));
    end
    #1;
    chk_rdy("starve_promo", 1'b0, 1'b0, 1'b1);
    tick();
    chk("promo_src", W'(pipe_src_o), W'(2));
    chk("promo_data", pipe_data_o, W'(256'h2000));
    chk("promo_clear", W'(starve_cnt_o), W'(0));
    #1;
    chk_rdy("after_promo", 1'b1, 1'b0, 1'b0);
    dllp_valid_i = 1'b0;
    tlp_valid_i  = 1'b0;
    tick();
    tick();

    // 5: backpressure holds a replay beat for 5 cycles
    rpl_valid_i = 1'b1;
    rpl_last_i  = 1'b1;
    rpl_data_i  = W'(256'hA500);
    tick();
    chk("bp_load_data", pipe_data_o, W'(256'hA500));
    pipe_ready_i = 1'b0;
    rpl_data_i   = W'(256'hA501);
    dllp_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_rdy("bp_hold", 1'b0, 1'b0, 1'b0);
      chk("bp_hold_data", pipe_data_o, W'(256'hA500));
      chk("bp_hold_src", W'(pipe_src_o), W'(1));
      chk("bp_hold_valid", W'(pipe_valid_o), W'(1));
      tick();
    end
    pipe_ready_i = 1'b1;
    #1;
    chk_rdy("bp_release", 1'b0, 1'b1, 1'b0);
    tick();
    chk("bp_next_data", pipe_data_o, W'(256'hA501));
    rpl_valid_i  = 1'b0;
    dllp_valid_i = 1'b0;
    tick();
    tick();

    // 6: link drop while locked on a TLP
    for (int i = 1; i <= 2; i++) begin
      tlp_valid_i = 1'b1;
      tlp_data_i  = W'(256'h6000 + i);
      tlp_last_i  = 1'b0;
      #1;
      chk_rdy("ld_beat", 1'b0, 1'b0, 1'b1);
      tick();
    end
    chk("ld_beat2", pipe_data_o, W'(256'h6002));
    dlcm_state_i = 2'd0;
    tlp_data_i   = W'(256'h6003);
    dllp_valid_i = 1'b1;
    pipe_ready_i = 1'b0;
    #1;
    chk_rdy("ld_drop", 1'b0, 1'b0, 1'b0);
    tick();
    chk("ld_hold_valid", W'(pipe_valid_o), W'(1));
    chk("ld_hold_data", pipe_data_o, W'(256'h6002));
    pipe_ready_i = 1'b1;
    #1;
    chk_rdy("ld_inactive", 1'b0, 1'b0, 1'b0);
    tick();
    chk("ld_drained", W'(pipe_valid_o), W'(0));
    chk_rdy("ld_after", 1'b0, 1'b0, 1'b0);
    dllp_valid_i = 1'b0;
    dlcm_state_i = 2'd3;
    rpl_valid_i  = 1'b1;
    rpl_data_i   = W'(256'hA600);
    #1;
    chk_rdy("ld_idle", 1'b0, 1'b1, 1'b0);
    tick();
    chk("ld_idle_src", W'(pipe_src_o), W'(1));
    rpl_valid_i = 1'b0;
    tlp_valid_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
